// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush controller for a 5-stage MIPS-style pipeline.
// Define HAZARD_FORWARDING_EN for load-use-only stalls; otherwise all RAW hazards against EX/MEM stall.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_next;
  logic [1:0] rem, rem_next;
  logic       haz_ex, haz_mem;
  logic       stall_need, stall_two;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  assign haz_ex  = ex_regwrite && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign haz_mem = mem_regwrite && (mem_rd != 5'd0) &&
                   ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

`ifdef HAZARD_FORWARDING_EN
  logic unused_haz_mem;
  assign unused_haz_mem = haz_mem;
  assign stall_need     = ex_memread && haz_ex;
  assign stall_two      = 1'b0;
`else
  logic unused_memread;
  assign unused_memread = ex_memread;
  assign stall_need     = haz_ex || haz_mem;
  assign stall_two      = haz_ex;
`endif

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_next   = RUN;
    rem_next     = 2'd0;
    if (!rst_n) begin
      state_next = RUN;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_next   = FLUSH;
    end else begin
      unique case (state)
        RUN: begin
          if (stall_need) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (stall_two) begin
              state_next = STALL;
              rem_next   = 2'd1;
            end
          end else if (id_jump) begin
            if_id_flush = 1'b1;
          end
        end
        STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (rem > 2'd1) begin
            state_next = STALL;
            rem_next   = rem - 2'd1;
          end
        end
        FLUSH: begin
          // ID holds the NOP inserted by the flush; nothing to check this cycle.
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      rem       <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
      if (!pc_write && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (if_id_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
